mem_wait_responder: RTL and testbench

- Synthesizable multi-port memory slave that serves the core's req/ack memory ports (imem, dmem, and additional masters later) from one shared word array.
- Adds features the current always-ready memory hookup lacks:
  - configurable wait-state latency;
  - round-robin arbitration across NUM_PORTS masters;
  - byte-enable writes;
  - error responses for misaligned or out-of-window accesses.
- Instantiated in processor benches and small SoC tops in place of zero-latency ack.

---
 rtl/mem_wait_responder_pkg.sv | 15 +
 rtl/mem_wait_responder_rr_arbiter.sv | 45 ++++
 rtl/mem_wait_responder.sv | 152 +++++++++++++++
 tb/tb_mem_wait_responder.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_wait_responder_pkg.sv
// rtl/mem_wait_responder_pkg.sv - shared types and helpers for the wait-state memory responder
package mem_wait_responder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  // Number of byte-offset address bits below the word index.
  function automatic int lane_bits(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/mem_wait_responder_rr_arbiter.sv
// rtl/mem_wait_responder_rr_arbiter.sv - round-robin arbiter; pointer advances only on an explicit strobe
module rr_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int IDX_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                 clk_i,
  input  logic                 arst_i,
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic                 adv_i,
  input  logic [IDX_W-1:0]     adv_idx_i,
  output logic                 gnt_valid_o,
  output logic [IDX_W-1:0]     gnt_idx_o
);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  int               k;

  // Scan from the highest offset down so the port closest to ptr_q wins.
  always_comb begin
    gnt_valid_o = 1'b0;
    gnt_idx_o   = ptr_q;
    k           = 0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      k = int'(ptr_q) + i;
      if (k >= NUM_PORTS) k = k - NUM_PORTS;
      if (req_i[IDX_W'(k)]) begin
        gnt_valid_o = 1'b1;
        gnt_idx_o   = IDX_W'(k);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (adv_i) begin
      ptr_d = (adv_idx_i == IDX_W'(NUM_PORTS - 1)) ? '0 : adv_idx_i + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/mem_wait_responder.sv
// rtl/mem_wait_responder.sv - multi-port word memory with wait states, round-robin arbitration and error responses
module mem_wait_responder
  import mem_wait_responder_pkg::*;
#(
  parameter int                    NUM_PORTS  = 2,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH_LOG2 = 10,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    LATENCY    = 2
) (
  input  logic                              clk_i,
  input  logic                              arst_i,
  input  logic [NUM_PORTS-1:0]              req_i,
  input  logic [NUM_PORTS-1:0]              we_i,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] be_i,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   addr_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]   wdata_i,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]   rdata_o,
  output logic [NUM_PORTS-1:0]              ack_o,
  output logic [NUM_PORTS-1:0]              err_o
);

  localparam int LANES = DATA_WIDTH / 8;
  localparam int LB    = lane_bits(DATA_WIDTH);
  localparam int IW    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CW    = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
  localparam logic [ADDR_WIDTH-1:0] LANE_MASK = ADDR_WIDTH'((1 << LB) - 1);

  state_e                         state_q, state_d;
  logic [CW-1:0]                  cnt_q, cnt_d;
  logic [IW-1:0]                  g_q, g_d;
  logic [NUM_PORTS-1:0]           ack_q, ack_d, err_q, err_d;
  logic [NUM_PORTS*DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic                  gnt_valid;
  logic [IW-1:0]         gnt_idx;
  logic [IW-1:0]         sel;
  logic                  adv;
  logic                  access;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [ADDR_WIDTH-1:0] offset;
  logic                  borrow;
  logic                  acc_err;
  logic [DEPTH_LOG2-1:0] idx;
  logic [LANES-1:0]      sel_be;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [DATA_WIDTH-1:0] mem_q [2**DEPTH_LOG2];

  rr_arbiter #(
    .NUM_PORTS(NUM_PORTS),
    .IDX_W    (IW)
  ) u_arb (
    .clk_i      (clk_i),
    .arst_i     (arst_i),
    .req_i      (req_i),
    .adv_i      (adv),
    .adv_idx_i  (g_q),
    .gnt_valid_o(gnt_valid),
    .gnt_idx_o  (gnt_idx)
  );

  // In IDLE only a zero-latency access uses the live grant; otherwise the latched one.
  assign sel       = (state_q == IDLE) ? gnt_idx : g_q;
  assign sel_addr  = addr_i[sel*ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_be    = be_i[sel*LANES +: LANES];
  assign sel_wdata = wdata_i[sel*DATA_WIDTH +: DATA_WIDTH];
  assign {borrow, offset} = {1'b0, sel_addr} - {1'b0, BASE_ADDR};
  assign idx       = offset[LB +: DEPTH_LOG2];
  assign acc_err   = borrow | (|(offset & LANE_MASK)) | (|(offset >> (LB + DEPTH_LOG2)));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    g_d     = g_q;
    access  = 1'b0;
    adv     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          g_d = gnt_idx;
          if (LATENCY == 0) begin
            state_d = RESP;
            access  = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CW'(LATENCY);
          end
        end
      end
      WAIT: begin
        if (!req_i[g_q]) begin
          state_d = IDLE;
        end else if (cnt_q == CW'(1)) begin
          state_d = RESP;
          access  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
        adv     = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ack_d   = '0;
    err_d   = '0;
    rdata_d = rdata_q;
    wr_en   = access & we_i[sel] & ~acc_err;
    if (access) begin
      ack_d[sel] = 1'b1;
      err_d[sel] = acc_err;
      rdata_d[sel*DATA_WIDTH +: DATA_WIDTH] = acc_err ? '0 : mem_q[idx];
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      g_q     <= '0;
      ack_q   <= '0;
      err_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      g_q     <= g_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int b = 0; b < LANES; b++) begin
        if (sel_be[b]) mem_q[idx][b*8 +: 8] <= sel_wdata[b*8 +: 8];
      end
    end
  end

  assign rdata_o = rdata_q;
  assign ack_o   = ack_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_mem_wait_responder.sv
// tb/tb_mem_wait_responder.sv - bench for mem_wait_responder at LATENCY=2 and LATENCY=0
module tb_mem_wait_responder;

  typedef struct {
    int          port;
    logic [31:0] rd;
    logic        chk;
    logic        er;
  } sb_t;

  typedef struct {
    int          p;
    logic        w;
    logic [3:0]  b;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        ck;
    logic        er;
  } vec_t;

  logic        clk = 1'b0;
  logic        arst  [2];
  logic [1:0]  req   [2];
  logic [1:0]  we    [2];
  logic [7:0]  be    [2];
  logic [63:0] addr  [2];
  logic [63:0] wdata [2];
  logic [63:0] rdata [2];
  logic [1:0]  ack   [2];
  logic [1:0]  err   [2];

  sb_t  q0[$];
  sb_t  q1[$];
  vec_t tbl [18];
  int   exp_next [2];
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  mem_wait_responder u_l2 (
    .clk_i(clk), .arst_i(arst[0]), .req_i(req[0]), .we_i(we[0]), .be_i(be[0]),
    .addr_i(addr[0]), .wdata_i(wdata[0]), .rdata_o(rdata[0]), .ack_o(ack[0]), .err_o(err[0])
  );

  mem_wait_responder #(.LATENCY(0)) u_l0 (
    .clk_i(clk), .arst_i(arst[1]), .req_i(req[1]), .we_i(we[1]), .be_i(be[1]),
    .addr_i(addr[1]), .wdata_i(wdata[1]), .rdata_o(rdata[1]), .ack_o(ack[1]), .err_o(err[1])
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic push(input int d, input sb_t e);
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  always @(negedge clk) begin : mon
    sb_t e;
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 2; p++) begin
        if (ack[d][p] === 1'b1) begin
          if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_ack: dut%0d port%0d acked with nothing pending", d, p);
          end else begin
            if (d == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            check($sformatf("ack_port_dut%0d", d), p, e.port);
            if (e.chk) check($sformatf("rdata_dut%0d_p%0d", d, p), rdata[d][p*32 +: 32], e.rd);
            check($sformatf("err_dut%0d_p%0d", d, p), err[d][p], e.er);
          end
        end
      end
    end
  end

  task automatic txn(input int d, input int p, input logic w, input logic [3:0] b,
                     input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                     input logic ck, input logic er, input int lat);
    int  cnt;
    sb_t e;
    @(posedge clk); #1;
    req[d][p] = 1'b1;
    we[d][p]  = w;
    be[d][p*4 +: 4]     = b;
    addr[d][p*32 +: 32]  = a;
    wdata[d][p*32 +: 32] = wd;
    e.port = p; e.rd = rd; e.chk = ck; e.er = er;
    push(d, e);
    cnt = 0;
    do begin
      @(posedge clk); #1;
      cnt++;
    end while (ack[d][p] !== 1'b1 && cnt < 20);
    check($sformatf("latency_dut%0d_a%0h", d, a), cnt, lat);
    req[d][p] = 1'b0;
    exp_next[d] = (p + 1) % 2;
  endtask

  // Holds the masked requests continuously; every ack must follow the previous one by gap cycles.
  task automatic burst(input int d, input logic [1:0] mask, input logic [31:0] a0, input logic [31:0] a1,
                       input logic [31:0] r0, input logic [31:0] r1, input int n, input int gap);
    int  cnt;
    int  p;
    sb_t e;
    @(posedge clk); #1;
    we[d]   = 2'b00;
    be[d]   = 8'h00;
    addr[d] = {a1, a0};
    req[d]  = mask;
    for (int i = 0; i < n; i++) begin
      p = (mask == 2'b11) ? exp_next[d] : (mask[0] ? 0 : 1);
      e.port = p; e.rd = (p == 0) ? r0 : r1; e.chk = 1'b1; e.er = 1'b0;
      push(d, e);
      cnt = 0;
      do begin
        @(posedge clk); #1;
        cnt++;
      end while (ack[d] === 2'b00 && cnt < 20);
      check($sformatf("burst_gap_dut%0d_%0d", d, i), cnt, (i == 0) ? gap - 1 : gap);
      exp_next[d] = (p + 1) % 2;
    end
    req[d] = 2'b00;
  endtask

  initial begin
    logic seen;
    tbl[0]  = '{1, 1'b1, 4'hF, 32'h40,   32'hDEADBEEF, 32'h0,        1'b0, 1'b0};
    tbl[1]  = '{1, 1'b0, 4'h0, 32'h40,   32'h0,        32'hDEADBEEF, 1'b1, 1'b0};
    tbl[2]  = '{0, 1'b1, 4'hF, 32'h80,   32'h11223344, 32'h0,        1'b0, 1'b0};
    tbl[3]  = '{0, 1'b1, 4'h5, 32'h80,   32'hAABBCCDD, 32'h11223344, 1'b1, 1'b0};
    tbl[4]  = '{1, 1'b0, 4'h0, 32'h80,   32'h0,        32'h11BB33DD, 1'b1, 1'b0};
    tbl[5]  = '{0, 1'b0, 4'h0, 32'h42,   32'h0,        32'h0,        1'b1, 1'b1};
    tbl[6]  = '{1, 1'b0, 4'h0, 32'h1000, 32'h0,        32'h0,        1'b1, 1'b1};
    tbl[7]  = '{0, 1'b1, 4'hF, 32'h44,   32'hCAFEF00D, 32'h0,        1'b0, 1'b0};
    tbl[8]  = '{0, 1'b1, 4'hF, 32'h43,   32'h0,        32'h0,        1'b1, 1'b1};
    tbl[9]  = '{1, 1'b1, 4'hF, 32'h0,    32'h5A5A5A5A, 32'h0,        1'b0, 1'b0};
    tbl[10] = '{0, 1'b1, 4'hF, 32'h1000, 32'h12345678, 32'h0,        1'b1, 1'b1};
    tbl[11] = '{1, 1'b0, 4'h0, 32'h0,    32'h0,        32'h5A5A5A5A, 1'b1, 1'b0};
    tbl[12] = '{1, 1'b0, 4'h0, 32'h44,   32'h0,        32'hCAFEF00D, 1'b1, 1'b0};
    tbl[13] = '{0, 1'b1, 4'hF, 32'h40,   32'h01020304, 32'hDEADBEEF, 1'b1, 1'b0};
    tbl[14] = '{0, 1'b0, 4'h0, 32'h40,   32'h0,        32'h01020304, 1'b1, 1'b0};
    tbl[15] = '{1, 1'b1, 4'hF, 32'hFFC,  32'h0BADC0DE, 32'h0,        1'b0, 1'b0};
    tbl[16] = '{0, 1'b0, 4'h0, 32'hFFC,  32'h0,        32'h0BADC0DE, 1'b1, 1'b0};
    tbl[17] = '{1, 1'b0, 4'h0, 32'h1FFC, 32'h0,        32'h0,        1'b1, 1'b1};

    for (int d = 0; d < 2; d++) begin
      arst[d] = 1'b1; req[d] = '0; we[d] = '0; be[d] = '0; addr[d] = '0; wdata[d] = '0;
      exp_next[d] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset_ack_dut%0d", d), ack[d], 0);
      check($sformatf("reset_err_dut%0d", d), err[d], 0);
      check($sformatf("reset_rdata_dut%0d", d), rdata[d], 0);
    end
    arst[0] = 1'b0;
    arst[1] = 1'b0;

    for (int i = 0; i < 18; i++) begin
      txn(0, tbl[i].p, tbl[i].w, tbl[i].b, tbl[i].a, tbl[i].wd, tbl[i].rd, tbl[i].ck, tbl[i].er, 3);
    end

    // Reset while a write to 0x40 is waiting: it must never commit or ack.
    @(posedge clk); #1;
    req[0][0] = 1'b1; we[0][0] = 1'b1; be[0][3:0] = 4'hF;
    addr[0][31:0] = 32'h40; wdata[0][31:0] = 32'h55555555;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("wait_no_ack", ack[0], 0);
    arst[0] = 1'b1;
    #1;
    check("midrst_rdata", rdata[0], 0);
    check("midrst_ack", ack[0], 0);
    @(posedge clk); #1;
    req[0] = '0; we[0] = '0; arst[0] = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      seen = seen | (|ack[0]);
    end
    check("midrst_no_ack", seen, 0);
    exp_next[0] = 0;

    burst(0, 2'b11, 32'h40, 32'h44, 32'h01020304, 32'hCAFEF00D, 8, 4);

    txn(1, 0, 1'b1, 4'hF, 32'h10, 32'hA5A5A5A5, 32'h0,        1'b0, 1'b0, 1);
    txn(1, 1, 1'b0, 4'h0, 32'h10, 32'h0,        32'hA5A5A5A5, 1'b1, 1'b0, 1);
    txn(1, 1, 1'b1, 4'hF, 32'h14, 32'h3C3C3C3C, 32'h0,        1'b0, 1'b0, 1);
    txn(1, 0, 1'b0, 4'h0, 32'h2000, 32'h0,      32'h0,        1'b1, 1'b1, 1);
    burst(1, 2'b01, 32'h10, 32'h0, 32'hA5A5A5A5, 32'h0, 3, 2);
    burst(1, 2'b11, 32'h10, 32'h14, 32'hA5A5A5A5, 32'h3C3C3C3C, 4, 2);

    repeat (4) @(posedge clk);
    #1;
    check("sb_empty_dut0", q0.size(), 0);
    check("sb_empty_dut1", q1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
